// File: rtl/led_blink_pkg.sv
// Shared constants for the LED blinker: bus widths and register-map helpers.
// Intervals sit at the bottom of the map. Enable and status follow the last channel.
package led_blink_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    localparam int INTERVAL_BASE = 0;
    localparam int ENABLE_OFFSET = 0;
    localparam int STATUS_OFFSET = 1;

    function automatic logic [ADDR_W-1:0] interval_addr(input int ch);
        return ADDR_W'(INTERVAL_BASE + ch);
    endfunction

    function automatic logic [ADDR_W-1:0] enable_addr(input int n_leds);
        return ADDR_W'(n_leds + ENABLE_OFFSET);
    endfunction

    function automatic logic [ADDR_W-1:0] status_addr(input int n_leds);
        return ADDR_W'(n_leds + STATUS_OFFSET);
    endfunction

endpackage

// File: rtl/led_blink_channel.sv
// One blink channel: a ms counter and a toggle flop.
// The LED toggles after every 'interval' ticks while the channel is active.
module led_blink_channel
    import led_blink_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tic,
    input  logic             en,
    input  logic [CNT_W-1:0] interval,
    input  logic             clr,
    output logic             led
);

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             led_reg, led_next;
    logic             active;

    assign active = en && (interval != '0);

    // An interval write takes priority over a coincident tick.
    always_comb begin
        cnt_next = cnt_reg;
        led_next = led_reg;
        if (!active) begin
            cnt_next = '0;
            led_next = 1'b0;
        end else if (clr) begin
            cnt_next = '0;
        end else if (tic) begin
            if (cnt_reg == interval - CNT_W'(1)) begin
                cnt_next = '0;
                led_next = ~led_reg;
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
            led_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            led_reg <= led_next;
        end
    end

    assign led = led_reg;

endmodule

// File: rtl/led_blink_core.sv
// Multi-channel LED blinker on an MMIO slot: interval/enable registers and a status readback.
// Each channel is driven by the 1 ms tic strobe.
module led_blink_core
    import led_blink_pkg::*;
#(
    parameter int N_LEDS = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tic,
    input  logic              cs,
    input  logic              write,
    input  logic              read,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wr_data,
    output logic [31:0]       rd_data,
    output logic [N_LEDS-1:0] led
);

    logic [CNT_W-1:0]  interval_reg [N_LEDS];
    logic [N_LEDS-1:0] enable_reg;
    logic [N_LEDS-1:0] led_bits;
    logic [N_LEDS-1:0] interval_hit;
    logic [DATA_W-1:0] rd_data_reg, rd_next;
    logic              wr_en, rd_en, enable_hit, status_hit;
    logic              unused_wr_bits;

    assign wr_en      = cs && write;
    assign rd_en      = cs && read;
    assign enable_hit = (addr == enable_addr(N_LEDS));
    assign status_hit = (addr == status_addr(N_LEDS));

    // Only the low bits of wr_data are stored.
    assign unused_wr_bits = ^wr_data;

    generate
        for (genvar gi = 0; gi < N_LEDS; gi++) begin : g_channel
            assign interval_hit[gi] = (addr == interval_addr(gi));

            led_blink_channel #(
                .CNT_W(CNT_W)
            ) u_channel (
                .clk     (clk),
                .rst     (rst),
                .tic     (tic),
                .en      (enable_reg[gi]),
                .interval(interval_reg[gi]),
                .clr     (wr_en && interval_hit[gi]),
                .led     (led_bits[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_LEDS; i++) begin
                interval_reg[i] <= '0;
            end
            enable_reg <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < N_LEDS; i++) begin
                if (interval_hit[i]) begin
                    interval_reg[i] <= wr_data[CNT_W-1:0];
                end
            end
            if (enable_hit) begin
                enable_reg <= wr_data[N_LEDS-1:0];
            end
        end
    end

    // Unmapped addresses fall through to zero.
    always_comb begin
        rd_next = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            if (interval_hit[i]) begin
                rd_next = DATA_W'(interval_reg[i]);
            end
        end
        if (enable_hit) begin
            rd_next = DATA_W'(enable_reg);
        end
        if (status_hit) begin
            rd_next = DATA_W'(led_bits);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            rd_data_reg <= rd_next;
        end
    end

    assign rd_data = rd_data_reg;
    assign led     = led_bits;

endmodule

// File: tb/tb_led_blink_core.sv
// Bench for led_blink_core: directed scenarios plus random bus/tic traffic against
// a model that derives each LED from elapsed ticks since the channel last restarted.
module tb_led_blink_core;

    localparam int N = 4;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          tic = 1'b0;
    logic          cs = 1'b0;
    logic          write = 1'b0;
    logic          read = 1'b0;
    logic [4:0]    addr = '0;
    logic [31:0]   wr_data = '0;
    logic [31:0]   rd_data;
    logic [N-1:0]  led;

    always #5 clk = ~clk;

    led_blink_core #(
        .N_LEDS(N),
        .CNT_W (W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .tic    (tic),
        .cs     (cs),
        .write  (write),
        .read   (read),
        .addr   (addr),
        .wr_data(wr_data),
        .rd_data(rd_data),
        .led    (led)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: LED = base XOR parity of (ticks / interval), ticks counted since last restart.
    int           m_interval [N];
    logic [N-1:0] m_en;
    int           m_ticks [N];
    logic         m_base [N];
    logic [31:0]  m_rd;

    function automatic logic [N-1:0] model_led();
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            if (m_interval[i] != 0)
                v[i] = m_base[i] ^ (((m_ticks[i] / m_interval[i]) % 2) == 1);
            else
                v[i] = m_base[i];
        end
        return v;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a, input logic [N-1:0] l);
        int ai;
        ai = int'(a);
        if (ai < N) return 32'(m_interval[ai]);
        if (ai == N) return 32'(m_en);
        if (ai == N + 1) return 32'(l);
        return 32'h0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock: update the model from pre-edge inputs, then compare.
    task automatic step();
        logic [N-1:0] led_now;
        logic         act, wr_i;
        led_now = model_led();
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_interval[i] = 0;
                m_ticks[i]    = 0;
                m_base[i]     = 1'b0;
            end
            m_en = '0;
            m_rd = '0;
        end else begin
            if (cs && read) m_rd = model_read(addr, led_now);
            for (int i = 0; i < N; i++) begin
                act  = m_en[i] && (m_interval[i] != 0);
                wr_i = cs && write && (int'(addr) == i);
                if (!act) begin
                    m_ticks[i] = 0;
                    m_base[i]  = 1'b0;
                end else if (wr_i) begin
                    m_base[i]  = led_now[i];
                    m_ticks[i] = 0;
                end else if (tic) begin
                    m_ticks[i]++;
                end
            end
            if (cs && write) begin
                if (int'(addr) < N) m_interval[int'(addr)] = int'(wr_data[W-1:0]);
                else if (int'(addr) == N) m_en = wr_data[N-1:0];
            end
        end
        @(posedge clk);
        #1;
        chk("led", 32'(led), 32'(model_led()));
        chk("rd_data", rd_data, m_rd);
        rst   = 1'b0;
        tic   = 1'b0;
        cs    = 1'b0;
        write = 1'b0;
        read  = 1'b0;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        cs = 1'b1; write = 1'b1; addr = 5'(a); wr_data = d;
        $display("wr addr=%0d data=%h", a, d);
        step();
    endtask

    task automatic rd_exp(input string tag, input int a, input logic [31:0] exp);
        cs = 1'b1; read = 1'b1; addr = 5'(a);
        step();
        $display("rd addr=%0d data=%h", a, rd_data);
        chk(tag, rd_data, exp);
    endtask

    // One tic pulse followed by idle cycles, giving a tic every 10 clocks.
    task automatic tick();
        tic = 1'b1;
        step();
        repeat (9) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        $display("reset");
    endtask

    int           toggles [N];
    logic [N-1:0] prev;
    int           a;

    initial begin
        for (int i = 0; i < N; i++) begin
            m_interval[i] = 0; m_ticks[i] = 0; m_base[i] = 1'b0;
        end
        m_en = '0;
        m_rd = '0;

        // Reset state and readback
        rst = 1'b1; step();
        do_reset();
        chk("reset_led", 32'(led), 32'h0);
        for (int i = 0; i <= N + 1; i++) rd_exp("reset_read", i, 32'h0);

        // Basic blink on channel 0
        wr(0, 32'd3);
        wr(N, 32'h1);
        for (int t = 1; t <= 6; t++) begin
            tick();
            chk("blink_led", 32'(led), (t >= 3 && t < 6) ? 32'h1 : 32'h0);
        end

        // Zero interval with enable set stays dark
        wr(1, 32'd0);
        wr(N, 32'h3);
        for (int t = 0; t < 20; t++) begin
            tick();
            chk("zero_interval_led1", 32'(led[1]), 32'h0);
        end

        // Disable mid-high, then re-enable
        wr(2, 32'd2);
        wr(N, 32'h7);
        tick();
        chk("ch2_before_rise", 32'(led[2]), 32'h0);
        tick();
        chk("ch2_rise", 32'(led[2]), 32'h1);
        wr(N, 32'h3);
        chk("ch2_disable_edge", 32'(led[2]), 32'h1);
        step();
        chk("ch2_disabled", 32'(led[2]), 32'h0);
        wr(N, 32'h7);
        tick();
        chk("ch2_reenable_1", 32'(led[2]), 32'h0);
        tick();
        chk("ch2_reenable_2", 32'(led[2]), 32'h1);

        // Interval write colliding with tic
        do_reset();
        wr(0, 32'd2);
        wr(N, 32'h1);
        tick();
        tick();
        chk("coll_high", 32'(led[0]), 32'h1);
        tick();
        cs = 1'b1; write = 1'b1; addr = 5'd0; wr_data = 32'd5; tic = 1'b1;
        $display("wr addr=0 data=%h with tic", 32'd5);
        step();
        chk("coll_no_toggle", 32'(led[0]), 32'h1);
        repeat (9) step();
        for (int t = 1; t <= 5; t++) begin
            tick();
            chk("coll_after", 32'(led[0]), (t < 5) ? 32'h1 : 32'h0);
        end

        // Independent channels
        do_reset();
        for (int i = 0; i < N; i++) begin
            wr(i, 32'(i + 1));
            toggles[i] = 0;
        end
        wr(N, 32'hF);
        for (int t = 0; t < 12; t++) begin
            prev = led;
            tick();
            for (int i = 0; i < N; i++) if (prev[i] != led[i]) toggles[i]++;
        end
        for (int i = 0; i < N; i++) chk("toggle_count", 32'(toggles[i]), 32'(12 / (i + 1)));
        rd_exp("status_read", N + 1, 32'h8);
        chk("status_vs_port", rd_data, 32'(led));

        // Bus edge cases
        wr(31, 32'hFFFF_FFFF);
        rd_exp("addr31_read", 31, 32'h0);
        rd_exp("enable_kept", N, 32'hF);
        wr(0, 32'hFFFF_FFFF);
        rd_exp("interval_trunc", 0, 32'h0000_FFFF);
        rd_exp("unmapped_read", N + 2, 32'h0);

        // Reset mid-blink, coinciding with a tic
        tick();
        rst = 1'b1; tic = 1'b1;
        step();
        chk("midreset_led", 32'(led), 32'h0);
        chk("midreset_rd", rd_data, 32'h0);
        for (int i = 0; i <= N; i++) rd_exp("midreset_read", i, 32'h0);

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            tic = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) begin
                a = $urandom_range(0, N + 2);
                if ($urandom_range(0, 7) == 0) a = 31;
                cs = 1'b1; write = 1'b1; addr = 5'(a);
                if (a < N && $urandom_range(0, 15) != 0) wr_data = 32'($urandom_range(0, 6));
                else wr_data = $urandom;
            end else if ($urandom_range(0, 7) == 0) begin
                cs = 1'b1; read = 1'b1; addr = 5'($urandom_range(0, 31));
            end
            if ($urandom_range(0, 499) == 0) rst = 1'b1;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_blink_core.md
Name: led_blink_core

Overview:
Multi-channel LED blinker that consumes the 1 ms `tic` pulse from the upstream millisecond counter. Each channel toggles its LED output every programmable number of milliseconds. Half-period and enable values are set through a simple MMIO register slot on the SoC bus. The block is the direct consumer of the ms tick and drives the board LEDs.

Parameters:
N_LEDS, 4, number of independent blink channels (1..30)
CNT_W, 16, width of per-channel half-period register and ms counter (max 65535 ms)

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  reset
tic  in  1  single-cycle 1 ms strobe from upstream ms counter
cs  in  1  slot chip select
write  in  1  write strobe, qualified by cs
read  in  1  read strobe, qualified by cs
addr  in  5  word register address
wr_data  in  32  write data
rd_data  out  32  read data, registered
led  out  N_LEDS  LED drive, active-high

Behaviour:
- Reset: rst is synchronous, active-high. While rst is asserted on a clk edge, the following values load:
  - all interval regs = 0
  - enable reg = 0
  - all counters = 0
  - led = 0
  - rd_data = 0
- Reset mid-blink takes effect on that same edge.
- Register map:
  - addr i (0..N_LEDS-1): interval[i], RW, wr_data[CNT_W-1:0].
  - addr N_LEDS: enable, RW, wr_data[N_LEDS-1:0].
  - addr N_LEDS+1: led status, RO.
  - Any other address reads 0; writes to it are ignored.
  - Unused upper bits read 0.
- Write: on an edge with cs&&write, the addressed register updates; the new value is effective from the next cycle.
- Read: on an edge with cs&&read, rd_data loads the addressed value (1-cycle latency). rd_data holds its value otherwise.
- Channel i is active when enable[i]==1 and interval[i]!=0.
- Inactive channel: counter forced to 0 and led[i] forced to 0 on every edge.
- Active channel, on an edge with tic==1:
  - if cnt==interval-1: cnt<=0 and led[i]<=~led[i];
  - else: cnt<=cnt+1.
- Active channel, tic==0: no change.
- Result: led toggles every interval ms, giving a full period of 2*interval ms. led changes on the edge that samples tic (no extra delay).
- Interval write to channel i: cnt[i]<=0 on that edge and led[i] is unchanged.
  - If tic coincides with the write, the write wins: no increment and no toggle on that edge.
- Enable 1->0: led off and cnt cleared on the next edge.
- Enable 0->1: counting starts from cnt=0 with led=0. The first toggle happens on the interval-th subsequent tic.
- Lowering interval below the current cnt cannot strand the counter, because every interval write clears cnt.
- Counter arithmetic is CNT_W bits unsigned. cnt never exceeds interval-1, so there is no wrap-around beyond the compare.
- tic held high for multiple cycles: each cycle counts as a tick. The upstream counter guarantees single-cycle pulses.

Decomposition:
- Package led_blink_pkg holds:
  - ADDR_W=5;
  - function/localparams for the enable address (N_LEDS) and status address (N_LEDS+1);
  - the register-offset constants.
- Sub-module led_blink_channel (one per LED, generate loop) holds the per-channel state:
  - inputs: clk, rst, tic, en, interval, clr (write pulse);
  - output: led bit;
  - contains the counter and toggle flop.
- The top level contains the register file, address decode and read mux.

Test Plan:
- Reset: after rst pulse, led=0, reading addr 0..N_LEDS+1 returns 0 each, rd_data valid one cycle after read.
- Basic blink: write interval[0]=3, enable=0x1, apply tic every 10 clks. Required:
  - led[0] rises on the 3rd tic edge and falls on the 6th;
  - other leds stay 0.
- Zero interval/disable:
  - interval[1]=0 with enable bit set keeps led[1]=0 for 20 tics.
  - Clearing the enable bit mid-high forces led[2]=0 on the next edge.
  - Re-enabling restarts the count; the first rise comes after a full interval.
- Write/tic collision: interval[0]=2 with led high and cnt=1. Write interval[0]=5 in the same cycle as tic. Required:
  - no toggle on that edge;
  - led stays high;
  - led falls after 5 further tics.
- Independent channels: intervals 1,2,3,4 all enabled, 12 tics. Required toggle counts are 12,6,4,3; the status register read matches the led port.
- Bus edges:
  - write to addr 31 has no effect;
  - read of addr 31 returns 0;
  - write 0xFFFF_FFFF to interval[0] stores 0xFFFF (CNT_W=16);
  - rst asserted mid-blink returns all state to reset values on that edge.
